ppu_timing_frontend: RTL and testbench

Front end for the PPU video-timing pins, directly upstream of `ppu_interrupt`. It does three things:
- Synchronises the four raw, asynchronous timing inputs into the `clock` domain and deglitches them.
- Drives the clean `burst_n`, `csync_n`, `hblank` and `vblank` levels that `ppu_interrupt` consumes.
- Derives single-cycle edge pulses plus line, frame and line-length measurements for host readout.

---
 rtl/ppu_timing_frontend_pkg.sv | 25 ++
 rtl/ppu_timing_frontend_deglitch.sv | 71 +++++++
 rtl/ppu_timing_frontend.sv | 162 ++++++++++++++++
 tb/tb_ppu_timing_frontend.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_timing_frontend_pkg.sv
// Shared definitions for the PPU timing front end: parameter defaults,
// inactive pin levels and a saturating counter helper.
package ppu_timing_frontend_pkg;

  // Default geometry
  localparam int unsigned DefSyncStages  = 2;
  localparam int unsigned DefFilterCycles = 4;
  localparam int unsigned DefLineW        = 9;
  localparam int unsigned DefFrameW       = 16;
  localparam int unsigned DefHlenW        = 12;

  // Levels the pins (and their synchronisers) take while idle or in reset
  localparam logic InactiveBurstN = 1'b1;
  localparam logic InactiveCsyncN = 1'b1;
  localparam logic InactiveHblank = 1'b0;
  localparam logic InactiveVblank = 1'b0;

  // 8-bit accumulator that sticks at 255 instead of wrapping
  function automatic logic [7:0] sat_add8(input logic [7:0] acc, input logic [2:0] inc);
    logic [8:0] sum;
    sum = {1'b0, acc} + {6'b0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/ppu_timing_frontend_deglitch.sv
// One timing channel: synchroniser chain, consecutive-cycle deglitch filter,
// registered edge pulses and a glitch strobe for rejected pulses.
module ppu_deglitch #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic strobe
);

  localparam int unsigned CntW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, fall_q;

  assign synced = sync_q[SYNC_STAGES-1];

  // Synchroniser chain, reset to the channel's inactive level
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Level follows only after the synced value has differed for FILTER_CYCLES cycles
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (synced != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = synced;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Filter state and edge pulses aligned with the first cycle of the new level
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level_q <= RESET_LEVEL;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
    end
  end

  // A partially counted excursion that returns to the level is a rejected glitch
  assign strobe = (synced == level_q) && (cnt_q != '0);
  assign level  = level_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: rtl/ppu_timing_frontend.sv
// PPU video-timing front end: cleans the four raw timing pins and derives
// edge pulses, line/frame counts and line-length measurements.
module ppu_timing_frontend
  import ppu_timing_frontend_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DefSyncStages,
  parameter int unsigned FILTER_CYCLES = DefFilterCycles,
  parameter int unsigned LINE_W        = DefLineW,
  parameter int unsigned FRAME_W       = DefFrameW,
  parameter int unsigned HLEN_W        = DefHlenW
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               burst_n_raw,
  input  logic               csync_n_raw,
  input  logic               hblank_raw,
  input  logic               vblank_raw,
  output logic               burst_n,
  output logic               csync_n,
  output logic               hblank,
  output logic               vblank,
  output logic               hblank_rise_o,
  output logic               vblank_rise_o,
  output logic               vblank_fall_o,
  output logic [LINE_W-1:0]  line_o,
  output logic [FRAME_W-1:0] frame_o,
  output logic [LINE_W-1:0]  lines_per_frame_o,
  output logic [HLEN_W-1:0]  line_len_o,
  output logic               line_len_valid_o,
  output logic [7:0]         glitch_count_o
);

  localparam logic [LINE_W-1:0] LineMax = '1;
  localparam logic [HLEN_W-1:0] HlenMax = '1;

  logic burst_rise, burst_fall, burst_strobe;
  logic csync_rise, csync_fall, csync_strobe;
  logic hblank_fall, hblank_strobe;
  logic vblank_strobe;
  logic unused_edges;

  ppu_deglitch #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_CYCLES (FILTER_CYCLES),
    .RESET_LEVEL   (InactiveBurstN)
  ) u_burst (
    .clock  (clock),
    .reset  (reset),
    .raw    (burst_n_raw),
    .level  (burst_n),
    .rise   (burst_rise),
    .fall   (burst_fall),
    .strobe (burst_strobe)
  );

  ppu_deglitch #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_CYCLES (FILTER_CYCLES),
    .RESET_LEVEL   (InactiveCsyncN)
  ) u_csync (
    .clock  (clock),
    .reset  (reset),
    .raw    (csync_n_raw),
    .level  (csync_n),
    .rise   (csync_rise),
    .fall   (csync_fall),
    .strobe (csync_strobe)
  );

  ppu_deglitch #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_CYCLES (FILTER_CYCLES),
    .RESET_LEVEL   (InactiveHblank)
  ) u_hblank (
    .clock  (clock),
    .reset  (reset),
    .raw    (hblank_raw),
    .level  (hblank),
    .rise   (hblank_rise_o),
    .fall   (hblank_fall),
    .strobe (hblank_strobe)
  );

  ppu_deglitch #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_CYCLES (FILTER_CYCLES),
    .RESET_LEVEL   (InactiveVblank)
  ) u_vblank (
    .clock  (clock),
    .reset  (reset),
    .raw    (vblank_raw),
    .level  (vblank),
    .rise   (vblank_rise_o),
    .fall   (vblank_fall_o),
    .strobe (vblank_strobe)
  );

  // Burst and csync carry no edge pulses; hblank fall is not consumed either
  assign unused_edges = ^{burst_rise, burst_fall, csync_rise, csync_fall, hblank_fall};

  logic [LINE_W-1:0]  line_q, lpf_q;
  logic [FRAME_W-1:0] frame_q;
  logic [HLEN_W-1:0]  hcnt_q, len_q;
  logic               seen_rise_q, valid_q;
  logic [7:0]         glitch_q;
  logic [2:0]         strobe_sum;

  assign strobe_sum = 3'(burst_strobe) + 3'(csync_strobe) + 3'(hblank_strobe)
                    + 3'(vblank_strobe);

  // Line and frame counters; a frame end takes priority over a coincident hblank rise
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      line_q  <= '0;
      lpf_q   <= '0;
      frame_q <= '0;
    end else if (vblank_fall_o) begin
      lpf_q   <= line_q;
      line_q  <= '0;
      frame_q <= frame_q + FRAME_W'(1);
    end else if (hblank_rise_o && (line_q != LineMax)) begin
      line_q <= line_q + LINE_W'(1);
    end
  end

  // Line length: clocks between successive hblank rises, saturating on overflow
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hcnt_q      <= '0;
      len_q       <= '0;
      seen_rise_q <= 1'b0;
      valid_q     <= 1'b0;
    end else if (hblank_rise_o) begin
      len_q       <= hcnt_q;
      hcnt_q      <= HLEN_W'(1);
      seen_rise_q <= 1'b1;
      // The first rise after reset only starts the measurement
      if (seen_rise_q) begin
        valid_q <= 1'b1;
      end
    end else if (hcnt_q != HlenMax) begin
      hcnt_q <= hcnt_q + HLEN_W'(1);
    end
  end

  // Rejected pulses across all channels, saturating at 255
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= sat_add8(glitch_q, strobe_sum);
    end
  end

  assign line_o            = line_q;
  assign frame_o           = frame_q;
  assign lines_per_frame_o = lpf_q;
  assign line_len_o        = len_q;
  assign line_len_valid_o  = valid_q;
  assign glitch_count_o    = glitch_q;

endmodule

// File: tb/tb_ppu_timing_frontend.sv
// Self-checking bench for ppu_timing_frontend: table-driven pulse widths,
// hand sequences for the multi-cycle corners, and a randomized run, all
// compared every cycle against a sample-window reference model.
module tb_ppu_timing_frontend;

  localparam int S    = 2;
  localparam int F    = 4;
  localparam int HL   = S + F + 1;
  localparam int LMAX = 511;
  localparam int HMAX = 4095;
  localparam logic [3:0] RstLevels = 4'b0011;  // {vblank, hblank, csync_n, burst_n}

  logic        clock, reset;
  logic        burst_n_raw, csync_n_raw, hblank_raw, vblank_raw;
  logic        burst_n, csync_n, hblank, vblank;
  logic        hblank_rise_o, vblank_rise_o, vblank_fall_o;
  logic [8:0]  line_o, lines_per_frame_o;
  logic [15:0] frame_o;
  logic [11:0] line_len_o;
  logic        line_len_valid_o;
  logic [7:0]  glitch_count_o;

  ppu_timing_frontend dut (
    .clock             (clock),
    .reset             (reset),
    .burst_n_raw       (burst_n_raw),
    .csync_n_raw       (csync_n_raw),
    .hblank_raw        (hblank_raw),
    .vblank_raw        (vblank_raw),
    .burst_n           (burst_n),
    .csync_n           (csync_n),
    .hblank            (hblank),
    .vblank            (vblank),
    .hblank_rise_o     (hblank_rise_o),
    .vblank_rise_o     (vblank_rise_o),
    .vblank_fall_o     (vblank_fall_o),
    .line_o            (line_o),
    .frame_o           (frame_o),
    .lines_per_frame_o (lines_per_frame_o),
    .line_len_o        (line_len_o),
    .line_len_valid_o  (line_len_valid_o),
    .glitch_count_o    (glitch_count_o)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each pin is judged on a window of its past samples.
  // hist[ch][m] is the raw value sampled m edges ago; the filter sees it S edges late.
  logic       hist [4][HL];
  logic [3:0] m_level;
  logic       m_hrise, m_vrise, m_vfall, m_valid, m_seen;
  int         m_line, m_frame, m_lpf, m_hcnt, m_len, m_glitch;

  task automatic model_reset();
    for (int ch = 0; ch < 4; ch++) begin
      for (int m = 0; m < HL; m++) hist[ch][m] = RstLevels[ch];
    end
    m_level = RstLevels;
    m_hrise = 0; m_vrise = 0; m_vfall = 0; m_valid = 0; m_seen = 0;
    m_line = 0; m_frame = 0; m_lpf = 0; m_hcnt = 0; m_len = 0; m_glitch = 0;
  endtask

  task automatic model_edge(input logic [3:0] r);
    int g;
    logic [3:0] rise_v, fall_v;
    logic all_diff;
    // Counters act on the pulses shown during the cycle that just ended
    if (m_vfall) begin
      m_lpf = m_line;
      m_line = 0;
      m_frame = (m_frame + 1) % 65536;
    end else if (m_hrise && m_line < LMAX) begin
      m_line++;
    end
    if (m_hrise) begin
      m_len = m_hcnt;
      m_hcnt = 1;
      if (m_seen) m_valid = 1;
      m_seen = 1;
    end else if (m_hcnt < HMAX) begin
      m_hcnt++;
    end
    g = 0;
    for (int ch = 0; ch < 4; ch++) begin
      for (int m = HL - 1; m > 0; m--) hist[ch][m] = hist[ch][m-1];
      hist[ch][0] = r[ch];
      // Back at the level right after a sample that disagreed: a rejected pulse
      if (hist[ch][S] == m_level[ch] && hist[ch][S+1] != m_level[ch]) g++;
      // F consecutive disagreeing samples flip the level
      all_diff = 1;
      for (int j = 0; j < F; j++) if (hist[ch][S+j] == m_level[ch]) all_diff = 0;
      rise_v[ch] = all_diff && !m_level[ch];
      fall_v[ch] = all_diff && m_level[ch];
      if (all_diff) m_level[ch] = !m_level[ch];
    end
    m_glitch = (m_glitch + g > 255) ? 255 : m_glitch + g;
    m_hrise = rise_v[2];
    m_vrise = rise_v[3];
    m_vfall = fall_v[3];
  endtask

  task automatic check_model();
    check("burst_n", burst_n, m_level[0]);
    check("csync_n", csync_n, m_level[1]);
    check("hblank", hblank, m_level[2]);
    check("vblank", vblank, m_level[3]);
    check("hblank_rise", hblank_rise_o, m_hrise);
    check("vblank_rise", vblank_rise_o, m_vrise);
    check("vblank_fall", vblank_fall_o, m_vfall);
    check("line", line_o, m_line);
    check("frame", frame_o, m_frame);
    check("lines_per_frame", lines_per_frame_o, m_lpf);
    check("line_len", line_len_o, m_len);
    check("line_len_valid", line_len_valid_o, m_valid);
    check("glitch_count", glitch_count_o, m_glitch);
  endtask

  // One clock: inputs were set between edges; compare 1 ns after the edge
  task automatic tick();
    logic [3:0] r;
    r = {vblank_raw, hblank_raw, csync_n_raw, burst_n_raw};
    @(posedge clock);
    #1;
    if (reset) model_edge(r);
    check_model();
  endtask

  task automatic idle_pins();
    burst_n_raw = 1'b1;
    csync_n_raw = 1'b1;
    hblank_raw  = 1'b0;
    vblank_raw  = 1'b0;
  endtask

  task automatic apply_reset();
    idle_pins();
    reset = 1'b0;
    model_reset();
    #1;
    check_model();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic hpulse(input int hi, input int lo);
    hblank_raw = 1'b1;
    repeat (hi) tick();
    hblank_raw = 1'b0;
    repeat (lo) tick();
  endtask

  typedef struct {
    int len;
    int exp_glitch;
    int exp_lines;
  } pulse_vec_t;

  pulse_vec_t vecs [5];
  int         lat;
  bit         seen, coincide;
  int         hold [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{len: 1, exp_glitch: 1, exp_lines: 0};
    vecs[1] = '{len: 2, exp_glitch: 1, exp_lines: 0};
    vecs[2] = '{len: 3, exp_glitch: 1, exp_lines: 0};  // 30 ns pulse
    vecs[3] = '{len: 4, exp_glitch: 0, exp_lines: 1};
    vecs[4] = '{len: 7, exp_glitch: 0, exp_lines: 1};

    idle_pins();
    reset = 1'b0;
    model_reset();
    @(posedge clock);
    #1;

    // Reset held with the pins toggling
    for (int i = 0; i < 6; i++) begin
      {vblank_raw, hblank_raw, csync_n_raw, burst_n_raw} = 4'($urandom);
      tick();
    end
    check("rst_burst_n", burst_n, 1);
    check("rst_csync_n", csync_n, 1);
    check("rst_hblank", hblank, 0);
    check("rst_vblank", vblank, 0);
    check("rst_glitch", glitch_count_o, 0);

    // hblank pulse widths around the filter threshold
    for (int v = 0; v < 5; v++) begin
      apply_reset();
      hblank_raw = 1'b1;
      repeat (vecs[v].len) tick();
      hblank_raw = 1'b0;
      repeat (14) tick();
      check("pulse_glitch", glitch_count_o, vecs[v].exp_glitch);
      check("pulse_lines", line_o, vecs[v].exp_lines);
    end

    // Latency of a clean rise and single-cycle pulse
    apply_reset();
    hblank_raw = 1'b1;
    lat = 0;
    seen = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick();
      if (hblank === 1'b1) begin
        seen = 1;
        lat = i;
      end
    end
    check("hblank_latency", lat, S + F);
    check("hblank_rise_first", hblank_rise_o, 1);
    tick();
    check("hblank_rise_single", hblank_rise_o, 0);
    check("line_after_rise", line_o, 1);
    hblank_raw = 1'b0;
    repeat (10) tick();

    // Line length with rises 100 cycles apart
    apply_reset();
    hpulse(10, 90);
    check("len_valid_after_first", line_len_valid_o, 0);
    hpulse(10, 90);
    check("len_valid_after_second", line_len_valid_o, 1);
    check("len_second", line_len_o, 100);
    hpulse(10, 90);
    check("len_third", line_len_o, 100);

    // Five lines then a frame end
    apply_reset();
    repeat (5) hpulse(10, 10);
    check("line_before_frame", line_o, 5);
    vblank_raw = 1'b1;
    repeat (10) tick();
    vblank_raw = 1'b0;
    repeat (20) tick();
    check("frame_lpf", lines_per_frame_o, 5);
    check("frame_line_cleared", line_o, 0);
    check("frame_count", frame_o, 1);

    // hblank rise coinciding with vblank fall, then reset mid-frame
    apply_reset();
    repeat (3) hpulse(10, 10);
    vblank_raw = 1'b1;
    repeat (10) tick();
    vblank_raw = 1'b0;
    hblank_raw = 1'b1;
    coincide = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (hblank_rise_o === 1'b1 && vblank_fall_o === 1'b1) coincide = 1;
    end
    check("coincide_seen", coincide, 1);
    check("coincide_lpf", lines_per_frame_o, 3);
    check("coincide_line", line_o, 0);
    check("coincide_frame", frame_o, 1);
    hblank_raw = 1'b0;
    repeat (10) tick();
    hpulse(10, 10);
    check("midframe_line", line_o, 1);
    check("midframe_valid", line_len_valid_o, 1);
    apply_reset();
    check("reset_line", line_o, 0);
    check("reset_frame", frame_o, 0);
    check("reset_lpf", lines_per_frame_o, 0);
    check("reset_len", line_len_o, 0);
    check("reset_valid", line_len_valid_o, 0);

    // Line-length counter saturation
    repeat (4100) tick();
    hpulse(10, 10);
    check("len_sat_first", line_len_o, HMAX);
    check("len_sat_first_valid", line_len_valid_o, 0);
    repeat (4200) tick();
    hpulse(10, 10);
    check("len_sat_second", line_len_o, HMAX);
    check("len_sat_second_valid", line_len_valid_o, 1);

    // Randomized pin activity, including short glitches on every channel
    apply_reset();
    for (int ch = 0; ch < 4; ch++) hold[ch] = $urandom_range(1, 10);
    for (int i = 0; i < 4000; i++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (hold[ch] == 0) begin
          case (ch)
            0: burst_n_raw = ~burst_n_raw;
            1: csync_n_raw = ~csync_n_raw;
            2: hblank_raw  = ~hblank_raw;
            default: vblank_raw = ~vblank_raw;
          endcase
          hold[ch] = $urandom_range(0, 9);
        end else begin
          hold[ch]--;
        end
      end
      tick();
    end
    check("random_glitch_saturated", glitch_count_o, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "simulation time limit reached");
  end

endmodule
